// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU), one operation in flight at a time.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i / ready_o     request handshake (accept = valid_i && ready_o)
//   funct3_i              RISC-V funct3 selecting the operation
//   rs1_i, rs2_i          operands a and b
//   rd_addr_i             destination register of the request
//   kill_i                flush, aborts any in-flight operation
//   busy_o                execute-stage stall (includes the accept cycle)
//   valid_o / out_ready_i result handshake (retire = valid_o && out_ready_i)
//   rd_addr_o, rd_data_o  registered result
//
// Build option: define MULDIV_REUSE_EN to remember the last divide and
// return a repeated DIV*/REM* with identical operands in one cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a new operation
// S_MUL  | shift-add multiply, MUL_BITS multiplier bits per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_DONE | result on rd_data_o/rd_addr_o, waiting for out_ready_i

module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            valid_o,
    input  logic            out_ready_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_BITS - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mcand;     // multiplicand (MUL) or divisor (DIV)
    logic [2*XLEN-1:0] r_prod;      // {acc, multiplier} or {remainder, quotient}
    logic [1:0]        r_op;        // funct3[1:0] of the operation in flight
    logic              r_neg_q;     // product / quotient sign
    logic              r_neg_r;     // remainder sign
    logic              r_valid;
    logic [4:0]        r_rd_addr;
    logic [XLEN-1:0]   r_rd_data;

    // ---------------- accept-cycle decode ----------------
    logic            w_accept, w_is_div, w_div_signed, w_sa, w_sb;
    logic            w_div_zero, w_ovf, w_special, w_hit;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res, w_hit_res;

    assign w_accept     = valid_i && (r_state == S_IDLE) && !kill_i;
    assign w_is_div     = funct3_i[2];
    assign w_div_signed = ~funct3_i[0];
    assign w_sa = w_is_div ? (w_div_signed & rs1_i[XLEN-1])
                           : (((funct3_i == 3'd1) || (funct3_i == 3'd2)) & rs1_i[XLEN-1]);
    assign w_sb = w_is_div ? (w_div_signed & rs2_i[XLEN-1])
                           : ((funct3_i == 3'd1) & rs2_i[XLEN-1]);
    assign w_mag_a = w_sa ? -rs1_i : rs1_i;
    assign w_mag_b = w_sb ? -rs2_i : rs2_i;

    assign w_div_zero = (rs2_i == '0);
    assign w_ovf      = w_div_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
    assign w_special  = w_div_zero || w_ovf;
    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = funct3_i[1] ? rs1_i : '1;
        else if (w_ovf)
            w_special_res = funct3_i[1] ? '0 : rs1_i;
    end

    // ---------------- multiply step ----------------
    logic [XLEN+MUL_BITS-1:0] w_pp, w_sum;
    logic [2*XLEN-1:0]        w_mul_nxt, w_mul_fin;
    logic [XLEN-1:0]          w_mul_res;

    assign w_pp      = {{MUL_BITS{1'b0}}, r_mcand} * {{XLEN{1'b0}}, r_prod[MUL_BITS-1:0]};
    assign w_sum     = {{MUL_BITS{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_pp;
    assign w_mul_nxt = {w_sum, r_prod[XLEN-1:MUL_BITS]};
    assign w_mul_fin = r_neg_q ? -w_mul_nxt : w_mul_nxt;
    assign w_mul_res = (r_op == 2'd0) ? w_mul_fin[XLEN-1:0] : w_mul_fin[2*XLEN-1:XLEN];

    // ---------------- divide step ----------------
    logic [XLEN:0]   w_trial, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_q_fin, w_r_fin, w_div_res;

    assign w_trial   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_diff    = w_trial - {1'b0, r_mcand};
    assign w_ge      = ~w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_quo_nxt = {r_prod[XLEN-2:0], w_ge};
    assign w_q_fin   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_div_res = r_op[1] ? w_r_fin : w_q_fin;

    // ---------------- last-divide reuse ----------------
`ifdef MULDIV_REUSE_EN
    logic            r_ru_vld, r_ru_sgn, r_sgn;
    logic [XLEN-1:0] r_ru_a, r_ru_b, r_ru_q, r_ru_r, r_rs1, r_rs2;

    assign w_hit     = r_ru_vld && (rs1_i == r_ru_a) && (rs2_i == r_ru_b)
                       && (r_ru_sgn == w_div_signed);
    assign w_hit_res = funct3_i[1] ? r_ru_r : r_ru_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ru_vld <= 1'b0;
            r_ru_sgn <= 1'b0;
            r_sgn    <= 1'b0;
            r_ru_a   <= '0;
            r_ru_b   <= '0;
            r_ru_q   <= '0;
            r_ru_r   <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
        end else begin
            if (w_accept) begin
                r_rs1 <= rs1_i;
                r_rs2 <= rs2_i;
                r_sgn <= w_div_signed;
                if (!w_is_div)
                    r_ru_vld <= 1'b0;
            end
            if (r_state == S_DIV) begin
                if (kill_i) begin
                    r_ru_vld <= 1'b0;
                end else if (r_cnt == '0) begin
                    r_ru_vld <= 1'b1;
                    r_ru_a   <= r_rs1;
                    r_ru_b   <= r_rs2;
                    r_ru_sgn <= r_sgn;
                    r_ru_q   <= w_q_fin;
                    r_ru_r   <= w_r_fin;
                end
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (!w_is_div)              w_state_nxt = S_MUL;
                else if (w_special || w_hit) w_state_nxt = S_DONE;
                else                        w_state_nxt = S_DIV;
            end
            S_MUL:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DIV:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (out_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (kill_i)
            w_state_nxt = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_op      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_valid   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= funct3_i[1:0];
                    r_rd_addr <= rd_addr_i;
                    r_neg_q   <= w_sa ^ w_sb;
                    r_neg_r   <= w_sa;
                    if (!w_is_div) begin
                        r_cnt   <= MUL_LAST;
                        r_mcand <= w_mag_a;
                        r_prod  <= {{XLEN{1'b0}}, w_mag_b};
                    end else begin
                        r_cnt   <= DIV_LAST;
                        r_mcand <= w_mag_b;
                        r_prod  <= {{XLEN{1'b0}}, w_mag_a};
                        if (w_special) begin
                            r_rd_data <= w_special_res;
                            r_valid   <= 1'b1;
                        end else if (w_hit) begin
                            r_rd_data <= w_hit_res;
                            r_valid   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_prod <= w_mul_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_rd_data <= w_mul_res;
                        r_valid   <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_prod <= {w_rem_nxt, w_quo_nxt};
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_rd_data <= w_div_res;
                        r_valid   <= 1'b1;
                    end
                end
                S_DONE: if (out_ready_i) r_valid <= 1'b0;
                default: r_valid <= 1'b0;
            endcase
            if (kill_i)
                r_valid <= 1'b0;
        end
    end

    assign ready_o   = (r_state == S_IDLE);
    assign busy_o    = (r_state != S_IDLE) || w_accept;
    assign valid_o   = r_valid;
    assign rd_addr_o = r_rd_addr;
    assign rd_data_o = r_rd_data;

endmodule
